// File: rtl/prog_loader.sv
// Instruction-memory loader: takes a length-prefixed byte frame over valid/ready, writes it to imem,
// then releases cpu_reset. Define LOADER_CHECKSUM_EN to require and verify a trailing checksum byte.
module prog_loader #(
  parameter int                ADDR_W    = 8,
  parameter int                DATA_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              restart,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [ADDR_W-1:0] A_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] A_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] D_ZERO = {DATA_W{1'b0}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
`ifdef LOADER_CHECKSUM_EN
    S_CHK   = 3'd3,
`endif
    S_FLUSH = 3'd4,
    S_DONE  = 3'd5,
    S_ERROR = 3'd6
  } state_t;

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] count_r, len_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic              imem_we_r;
  logic              in_ready_r, busy_r, done_r, cpu_reset_r;
  logic              accept_s, last_s;

`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_r;
  logic              error_r;

  function automatic logic [DATA_W-1:0] sum_add(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    return a + b;
  endfunction
`endif

  // restart outranks a simultaneous byte, so such a byte is never accepted
  assign accept_s = in_valid & in_ready_r & ~restart;
  // a length of 0 wraps to len_r-1 = all ones, giving 2**ADDR_W words
  assign last_s   = (count_r == (len_r - A_ONE));

  // Next-state logic
  always_comb begin
    state_s = state_r;
    if (restart) begin
      state_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE:  state_s = S_LEN;
        S_LEN: begin
          if (accept_s) state_s = S_DATA;
          else          state_s = S_LEN;
        end
        S_DATA: begin
          if (accept_s && last_s) begin
`ifdef LOADER_CHECKSUM_EN
            state_s = S_CHK;
`else
            state_s = S_FLUSH;
`endif
          end else begin
            state_s = S_DATA;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHK: begin
          if (accept_s) begin
            if (sum_add(sum_r, in_data) == D_ZERO) state_s = S_FLUSH;
            else                                   state_s = S_ERROR;
          end else begin
            state_s = S_CHK;
          end
        end
`endif
        S_FLUSH: state_s = S_DONE;
        S_DONE:  state_s = S_DONE;
        S_ERROR: state_s = S_ERROR;
        default: state_s = S_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_r <= S_IDLE;
    else          state_r <= state_s;
  end

  // Write port, word counter and running sum
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      imem_we_r <= 1'b0;
      addr_r    <= BASE_ADDR;
      wdata_r   <= D_ZERO;
      count_r   <= A_ZERO;
      len_r     <= A_ZERO;
`ifdef LOADER_CHECKSUM_EN
      sum_r     <= D_ZERO;
`endif
    end else if (restart) begin
      imem_we_r <= 1'b0;
      count_r   <= A_ZERO;
`ifdef LOADER_CHECKSUM_EN
      sum_r     <= D_ZERO;
`endif
    end else begin
      imem_we_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          count_r <= A_ZERO;
`ifdef LOADER_CHECKSUM_EN
          sum_r   <= D_ZERO;
`endif
        end
        S_LEN: begin
          if (accept_s) len_r <= ADDR_W'(in_data);
        end
        S_DATA: begin
          if (accept_s) begin
            imem_we_r <= 1'b1;
            addr_r    <= BASE_ADDR + count_r;
            wdata_r   <= in_data;
            count_r   <= count_r + A_ONE;
`ifdef LOADER_CHECKSUM_EN
            sum_r     <= sum_add(sum_r, in_data);
`endif
          end
        end
        default: ;
      endcase
    end
  end

  // Status outputs registered from the next state so they track state_r exactly
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_ready_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      cpu_reset_r <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
      error_r     <= 1'b0;
`endif
    end else begin
`ifdef LOADER_CHECKSUM_EN
      in_ready_r  <= (state_s == S_LEN) || (state_s == S_DATA) || (state_s == S_CHK);
      busy_r      <= (state_s == S_LEN) || (state_s == S_DATA) || (state_s == S_CHK);
      error_r     <= (state_s == S_ERROR);
`else
      in_ready_r  <= (state_s == S_LEN) || (state_s == S_DATA);
      busy_r      <= (state_s == S_LEN) || (state_s == S_DATA);
`endif
      done_r      <= (state_s == S_DONE);
      cpu_reset_r <= (state_s != S_DONE);
    end
  end

  // restart in the cycle after an accept kills that pending write before memory samples it
  assign imem_we    = imem_we_r & ~restart;
  assign imem_addr  = addr_r;
  assign imem_wdata = wdata_r;
  assign in_ready   = in_ready_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign cpu_reset  = cpu_reset_r;
`ifdef LOADER_CHECKSUM_EN
  assign error      = error_r;
`else
  assign error      = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: two instances (BASE_ADDR 0 and 254) share one random frame stream.
module tb_prog_loader;
  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       in_valid = 1'b0;
  logic       restart = 1'b0;
  logic [7:0] in_data = 8'h00;

  logic       in_ready0, imem_we0, cpu_reset0, busy0, done0, error0;
  logic       in_ready1, imem_we1, cpu_reset1, busy1, done1, error1;
  logic [7:0] imem_addr0, imem_wdata0, imem_addr1, imem_wdata1;

  prog_loader #(.ADDR_W(8), .DATA_W(8), .BASE_ADDR(8'd0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready0),
    .restart(restart), .imem_we(imem_we0), .imem_addr(imem_addr0), .imem_wdata(imem_wdata0),
    .cpu_reset(cpu_reset0), .busy(busy0), .done(done0), .error(error0));

  prog_loader #(.ADDR_W(8), .DATA_W(8), .BASE_ADDR(8'd254)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready1),
    .restart(restart), .imem_we(imem_we1), .imem_addr(imem_addr1), .imem_wdata(imem_wdata1),
    .cpu_reset(cpu_reset1), .busy(busy1), .done(done1), .error(error1));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         k;
    logic [7:0] d;
    int         c;
  } wr_t;

  wr_t        exp0_q[$];
  wr_t        exp1_q[$];
  logic [7:0] pl[$];
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic mon_write(input int inst, input logic [7:0] a, input logic [7:0] d, input logic cr);
    wr_t        e;
    logic [7:0] ea;
    check("cpu_reset_during_write", {31'd0, cr}, 32'd1);
    if ((inst == 0) ? (exp0_q.size() == 0) : (exp1_q.size() == 0)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_write: inst%0d got addr %0h data %0h, expected no write", inst, a, d);
    end else begin
      e  = (inst == 0) ? exp0_q.pop_front() : exp1_q.pop_front();
      ea = (inst == 0) ? 8'(e.k) : 8'(254 + e.k);
      check(inst == 0 ? "write_addr0" : "write_addr1", {24'd0, a}, {24'd0, ea});
      check(inst == 0 ? "write_data0" : "write_data1", {24'd0, d}, {24'd0, e.d});
      check(inst == 0 ? "write_cycle0" : "write_cycle1", cyc, e.c);
    end
  endtask

  // Monitor: every write presented by either instance is popped and compared
  always @(negedge clk) begin
    if (imem_we0) mon_write(0, imem_addr0, imem_wdata0, cpu_reset0);
    if (imem_we1) mon_write(1, imem_addr1, imem_wdata1, cpu_reset1);
  end

  task automatic push(input int k, input logic [7:0] d, input int c);
    wr_t e;
    e.k = k; e.d = d; e.c = c;
    exp0_q.push_back(e);
    exp1_q.push_back(e);
  endtask

  // Called at posedge+2; returns at posedge+2 after the accepting edge with in_valid dropped
  task automatic send(input logic [7:0] b, output int acc_cyc);
    int t = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready0 && t < 300) begin
      @(posedge clk); #2;
      t++;
    end
    if (!in_ready0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 300 cycles");
    end
    @(posedge clk); #2;
    acc_cyc  = cyc;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic check_end(input bit ok);
    logic exp_err;
`ifdef LOADER_CHECKSUM_EN
    exp_err = ~ok;
`else
    exp_err = 1'b0;
`endif
    check("end0_cpu_reset", {31'd0, cpu_reset0}, 32'd1);
    check("end0_done", {31'd0, done0}, 32'd0);
    check("end0_in_ready", {31'd0, in_ready0}, 32'd0);
    check("end0_busy", {31'd0, busy0}, 32'd0);
    in_valid = 1'b1;
    in_data  = 8'($urandom);
    @(posedge clk); #2;
    check("end1_done", {31'd0, done0}, {31'd0, ok});
    check("end1_cpu_reset", {31'd0, cpu_reset0}, {31'd0, ~ok});
    check("end1_error", {31'd0, error0}, {31'd0, exp_err});
    check("end1_busy", {31'd0, busy0}, 32'd0);
    check("end1_done_inst1", {31'd0, done1}, {31'd0, ok});
    repeat (3) begin
      in_data  = 8'($urandom);
      in_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #2;
    end
    in_valid = 1'b0;
    check("end_in_ready", {31'd0, in_ready0}, 32'd0);
    check("pending_writes", exp0_q.size() + exp1_q.size(), 32'd0);
  endtask

  // Sends len_b, the bytes in pl and (with checksum) chk_b; gap<0 means random gaps
  task automatic send_frame(input logic [7:0] len_b, input logic [7:0] chk_b, input int gap);
    int         c;
    int         g;
    logic [7:0] s = 8'h00;
    bit         ok;
    send(len_b, c);
    for (int k = 0; k < pl.size(); k++) begin
      send(pl[k], c);
      push(k, pl[k], c);
      s = s + pl[k];
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      if (k != pl.size() - 1) idle(g);
    end
`ifdef LOADER_CHECKSUM_EN
    send(chk_b, c);
    ok = (8'(s + chk_b) == 8'h00);
`else
    ok = 1'b1;
    if (chk_b == 8'h00) ok = 1'b1;
`endif
    check_end(ok);
  endtask

  function automatic logic [7:0] good_chk();
    logic [7:0] s = 8'h00;
    foreach (pl[i]) s = s + pl[i];
    return 8'h00 - s;
  endfunction

  task automatic fill_random(input int n);
    pl.delete();
    for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
  endtask

  task automatic do_restart();
    restart  = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'($urandom);
    @(posedge clk); #2;
    restart  = 1'b0;
    in_valid = 1'b0;
    check("rst_idle_in_ready", {31'd0, in_ready0}, 32'd0);
    check("rst_idle_busy", {31'd0, busy0}, 32'd0);
    check("rst_idle_done", {31'd0, done0}, 32'd0);
    check("rst_idle_error", {31'd0, error0}, 32'd0);
    check("rst_idle_cpu_reset", {31'd0, cpu_reset0}, 32'd1);
    @(posedge clk); #2;
    check("rst_len_in_ready", {31'd0, in_ready0}, 32'd1);
    check("rst_len_busy", {31'd0, busy0}, 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, {31'd0, in_ready0}, 32'd0);
    check({tag, "_imem_we"}, {31'd0, imem_we0}, 32'd0);
    check({tag, "_imem_addr0"}, {24'd0, imem_addr0}, 32'd0);
    check({tag, "_imem_addr1"}, {24'd0, imem_addr1}, 32'd254);
    check({tag, "_imem_wdata"}, {24'd0, imem_wdata0}, 32'd0);
    check({tag, "_cpu_reset"}, {31'd0, cpu_reset0}, 32'd1);
    check({tag, "_busy"}, {31'd0, busy0}, 32'd0);
    check({tag, "_done"}, {31'd0, done0}, 32'd0);
    check({tag, "_error"}, {31'd0, error0}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    #3 reset_n = 1'b0;
    #1 check_reset_vals("reset");
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk); #2;
    check("boot_in_ready", {31'd0, in_ready0}, 32'd1);
    check("boot_busy", {31'd0, busy0}, 32'd1);

    // Known frame 3 x {21,12,30}, checksum 9D, bytes back to back
    pl = '{8'h21, 8'h12, 8'h30};
    send_frame(8'h03, 8'h9D, 0);
    do_restart();
`ifdef LOADER_CHECKSUM_EN
    send_frame(8'h03, 8'h9C, 0);
    do_restart();
    send_frame(8'h03, 8'h9D, 0);
    do_restart();
`endif

    // Full-depth frame: length byte 0 means 256 words
    fill_random(256);
    send_frame(8'h00, good_chk(), 0);
    do_restart();

    // Three idle cycles between every data byte
    fill_random(5);
    send_frame(8'h05, good_chk(), 3);
    do_restart();

    // restart right after the second data byte: that write and the concurrent byte are dropped
    fill_random(5);
    send(8'h05, c);
    send(pl[0], c);
    push(0, pl[0], c);
    send(pl[1], c);
    do_restart();
    check("restart_pending", exp0_q.size() + exp1_q.size(), 32'd0);
    fill_random(4);
    send_frame(8'h04, good_chk(), 0);
    do_restart();

    // reset_n mid-DATA after two of five bytes
    fill_random(5);
    send(8'h05, c);
    send(pl[0], c);
    push(0, pl[0], c);
    send(pl[1], c);
    reset_n = 1'b0;
    #1 check_reset_vals("midrst");
    @(posedge clk); #2;
    reset_n = 1'b1;
    check("midrst_pending", exp0_q.size() + exp1_q.size(), 32'd0);
    @(posedge clk); #2;
    fill_random(5);
    send_frame(8'h05, good_chk(), 0);
    do_restart();

    // Random frames, some with corrupted checksum when checking is built in
    for (int f = 0; f < 10; f++) begin
      int         n;
      logic [7:0] chk;
      n = int'($urandom_range(1, 24));
      fill_random(n);
      chk = good_chk();
`ifdef LOADER_CHECKSUM_EN
      if ($urandom_range(0, 3) == 0) chk = chk + 8'($urandom_range(1, 255));
`endif
      send_frame(8'(n), chk, -1);
      do_restart();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
